// File: rtl/jzjpcc_memory.sv
// Memory stage of the jzjpcc pipeline: data-memory handshake, load extraction
// and the memory->writeback pipeline register.
module jzjpcc_memory #(
  parameter int DMEM_ADDR_B = 30
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            aluResult,
  input  logic [4:0]             rdAddr,
  input  logic [1:0]             rdSource,
  input  logic                   rdWriteEnable,
  input  logic                   memoryWriteEnable,
  input  logic [2:0]             funct3,
  input  logic [31:0]            memDataToWrite,
  input  logic [3:0]             memByteMask,
  output logic                   dmemRequest,
  output logic [DMEM_ADDR_B-1:0] dmemAddress,
  output logic                   dmemWriteEnable,
  output logic [31:0]            dmemWriteData,
  output logic [3:0]             dmemByteMask,
  input  logic [31:0]            dmemReadData,
  input  logic                   dmemAck,
  output logic                   stallUpstream,
  output logic [4:0]             wbRdAddr,
  output logic [31:0]            wbRdData,
  output logic                   wbRdWriteEnable
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_reg, state_next;
  logic        mem_op;
  logic        complete;
  logic [1:0]  off;
  logic [7:0]  byte_lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;
  logic [31:0] rd_value;

  assign mem_op = memoryWriteEnable | (rdSource == 2'b01);
  assign off    = aluResult[1:0];

  // Request side depends only on the held execute-register inputs.
  assign dmemAddress     = aluResult[DMEM_ADDR_B+1:2];
  assign dmemWriteEnable = memoryWriteEnable;
  assign dmemWriteData   = memDataToWrite;
  assign dmemByteMask    = memoryWriteEnable ? memByteMask : 4'b1111;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = dmemReadData[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = byte_lane[off];
  // Halfword loads ignore off[0]: misaligned halves simply read the aligned half.
  assign sel_half = off[1] ? dmemReadData[31:16] : dmemReadData[15:0];

  always_comb begin
    load_data = dmemReadData;
    case (funct3)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_data = {24'h0, sel_byte};
      3'b101:  load_data = {16'h0, sel_half};
      default: load_data = dmemReadData;
    endcase
  end

  assign rd_value = (rdSource == 2'b01) ? load_data : aluResult;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    dmemRequest   = 1'b0;
    stallUpstream = 1'b0;
    complete      = 1'b0;
    case (state_reg)
      IDLE: begin
        dmemRequest   = mem_op;
        stallUpstream = mem_op & ~dmemAck;
        complete      = ~mem_op | dmemAck;
        if (mem_op && !dmemAck) state_next = WAIT;
      end
      WAIT: begin
        dmemRequest   = 1'b1;
        stallUpstream = ~dmemAck;
        complete      = dmemAck;
        if (dmemAck) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      dmemRequest   = 1'b0;
      stallUpstream = 1'b0;
    end
  end

  // A cycle without completion sends a bubble; address/data hold their last value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wbRdAddr        <= 5'd0;
      wbRdData        <= 32'd0;
      wbRdWriteEnable <= 1'b0;
    end else if (complete) begin
      wbRdAddr        <= rdAddr;
      wbRdData        <= rd_value;
      wbRdWriteEnable <= rdWriteEnable;
    end else begin
      wbRdWriteEnable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jzjpcc_memory.sv
// Directed self-checking bench for the jzjpcc memory stage.
module tb_jzjpcc_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] aluResult;
  logic [4:0]  rdAddr;
  logic [1:0]  rdSource;
  logic        rdWriteEnable;
  logic        memoryWriteEnable;
  logic [2:0]  funct3;
  logic [31:0] memDataToWrite;
  logic [3:0]  memByteMask;
  logic        dmemRequest;
  logic [29:0] dmemAddress;
  logic        dmemWriteEnable;
  logic [31:0] dmemWriteData;
  logic [3:0]  dmemByteMask;
  logic [31:0] dmemReadData;
  logic        dmemAck;
  logic        stallUpstream;
  logic [4:0]  wbRdAddr;
  logic [31:0] wbRdData;
  logic        wbRdWriteEnable;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  jzjpcc_memory #(.DMEM_ADDR_B(30)) dut (
    .clock(clock), .reset(reset), .aluResult(aluResult), .rdAddr(rdAddr),
    .rdSource(rdSource), .rdWriteEnable(rdWriteEnable),
    .memoryWriteEnable(memoryWriteEnable), .funct3(funct3),
    .memDataToWrite(memDataToWrite), .memByteMask(memByteMask),
    .dmemRequest(dmemRequest), .dmemAddress(dmemAddress),
    .dmemWriteEnable(dmemWriteEnable), .dmemWriteData(dmemWriteData),
    .dmemByteMask(dmemByteMask), .dmemReadData(dmemReadData), .dmemAck(dmemAck),
    .stallUpstream(stallUpstream), .wbRdAddr(wbRdAddr), .wbRdData(wbRdData),
    .wbRdWriteEnable(wbRdWriteEnable)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [4:0] rd, input logic [1:0] src,
                       input logic rdwe, input logic mwe, input logic [2:0] f3,
                       input logic [31:0] wdata, input logic [3:0] mask,
                       input logic [31:0] rdata, input logic ack);
    aluResult = alu; rdAddr = rd; rdSource = src; rdWriteEnable = rdwe;
    memoryWriteEnable = mwe; funct3 = f3; memDataToWrite = wdata; memByteMask = mask;
    dmemReadData = rdata; dmemAck = ack;
  endtask

  // One-cycle load with same-cycle ack, checking the writeback value.
  task automatic load1(input string tag, input logic [31:0] alu, input logic [2:0] f3,
                       input logic [31:0] rdata, input logic [31:0] exp);
    drive(alu, 5'd3, 2'b01, 1'b1, 1'b0, f3, 32'h0, 4'h0, rdata, 1'b1);
    @(negedge clock);
    chk({tag, "_stall"}, {31'h0, stallUpstream}, 32'h0);
    @(posedge clock); #1;
    chk({tag, "_data"}, wbRdData, exp);
  endtask

  initial begin
    reset = 1'b1;
    drive(32'h104, 5'd1, 2'b01, 1'b1, 1'b0, 3'b010, 32'h0, 4'h0, 32'h0, 1'b0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_req", {31'h0, dmemRequest}, 32'h0);
    chk("rst_stall", {31'h0, stallUpstream}, 32'h0);
    chk("rst_wb", {wbRdAddr, wbRdWriteEnable, wbRdData[25:0]}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // ALU op, with a stray ack that must be ignored
    drive(32'h12345678, 5'd5, 2'b00, 1'b1, 1'b0, 3'b010, 32'h0, 4'h0, 32'h0, 1'b1);
    @(negedge clock);
    chk("alu_req", {31'h0, dmemRequest}, 32'h0);
    chk("alu_stall", {31'h0, stallUpstream}, 32'h0);
    @(posedge clock); #1;
    chk("alu_data", wbRdData, 32'h12345678);
    chk("alu_addr", {27'h0, wbRdAddr}, 32'd5);
    chk("alu_we", {31'h0, wbRdWriteEnable}, 32'h1);

    // LB with address/mask checks
    drive(32'h103, 5'd3, 2'b01, 1'b1, 1'b0, 3'b000, 32'h0, 4'h0, 32'h80FF7F01, 1'b1);
    @(negedge clock);
    chk("lb_req", {31'h0, dmemRequest}, 32'h1);
    chk("lb_addr", {2'b0, dmemAddress}, 32'h40);
    chk("lb_mask", {28'h0, dmemByteMask}, 32'hF);
    chk("lb_stall", {31'h0, stallUpstream}, 32'h0);
    @(posedge clock); #1;
    chk("lb_data", wbRdData, 32'hFFFFFF80);
    load1("lbu", 32'h103, 3'b100, 32'h80FF7F01, 32'h00000080);
    load1("lb0", 32'h100, 3'b000, 32'h80FF7F01, 32'h00000001);
    load1("lb1", 32'h101, 3'b000, 32'h80FF7F01, 32'h0000007F);
    load1("lb2", 32'h102, 3'b000, 32'h80FF7F01, 32'hFFFFFFFF);
    load1("lh", 32'h102, 3'b001, 32'h8001FFFF, 32'hFFFF8001);
    load1("lhu", 32'h102, 3'b101, 32'h8001FFFF, 32'h00008001);
    load1("lh0", 32'h100, 3'b001, 32'h8001FFFF, 32'hFFFFFFFF);
    load1("lw1", 32'h101, 3'b010, 32'h8001FFFF, 32'h8001FFFF);
    load1("lw3", 32'h103, 3'b011, 32'h8001FFFF, 32'h8001FFFF);

    // Store with ack delayed three cycles
    drive(32'h200, 5'd0, 2'b00, 1'b0, 1'b1, 3'b010, 32'hAABB0000, 4'b1100, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      dmemAck = (i == 3);
      @(negedge clock);
      chk($sformatf("st_req%0d", i), {31'h0, dmemRequest}, 32'h1);
      chk($sformatf("st_we%0d", i), {31'h0, dmemWriteEnable}, 32'h1);
      chk($sformatf("st_mask%0d", i), {28'h0, dmemByteMask}, 32'hC);
      chk($sformatf("st_wdata%0d", i), dmemWriteData, 32'hAABB0000);
      chk($sformatf("st_addr%0d", i), {2'b0, dmemAddress}, 32'h80);
      chk($sformatf("st_stall%0d", i), {31'h0, stallUpstream}, (i < 3) ? 32'h1 : 32'h0);
      @(posedge clock); #1;
      chk($sformatf("st_bubble%0d", i), {31'h0, wbRdWriteEnable}, 32'h0);
    end
    chk("st_data", wbRdData, 32'h200);

    // Load with ack one cycle late: one bubble then the result
    drive(32'h300, 5'd9, 2'b01, 1'b1, 1'b0, 3'b010, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
    @(negedge clock);
    chk("dl_stall0", {31'h0, stallUpstream}, 32'h1);
    @(posedge clock); #1;
    chk("dl_bubble", {31'h0, wbRdWriteEnable}, 32'h0);
    dmemAck = 1'b1;
    @(negedge clock);
    chk("dl_req1", {31'h0, dmemRequest}, 32'h1);
    chk("dl_stall1", {31'h0, stallUpstream}, 32'h0);
    @(posedge clock); #1;
    chk("dl_we", {31'h0, wbRdWriteEnable}, 32'h1);
    chk("dl_data", wbRdData, 32'hCAFEF00D);
    chk("dl_addr", {27'h0, wbRdAddr}, 32'd9);

    // Back-to-back LW, LW, ALU with immediate ack
    drive(32'h400, 5'd10, 2'b01, 1'b1, 1'b0, 3'b010, 32'h0, 4'h0, 32'h11111111, 1'b1);
    @(negedge clock);
    chk("bb0_stall", {31'h0, stallUpstream}, 32'h0);
    @(posedge clock); #1;
    chk("bb0_data", wbRdData, 32'h11111111);
    chk("bb0_addr", {27'h0, wbRdAddr}, 32'd10);
    drive(32'h404, 5'd11, 2'b01, 1'b1, 1'b0, 3'b010, 32'h0, 4'h0, 32'h22222222, 1'b1);
    @(negedge clock);
    chk("bb1_stall", {31'h0, stallUpstream}, 32'h0);
    @(posedge clock); #1;
    chk("bb1_data", wbRdData, 32'h22222222);
    chk("bb1_we", {31'h0, wbRdWriteEnable}, 32'h1);
    drive(32'h33333333, 5'd12, 2'b00, 1'b1, 1'b0, 3'b010, 32'h0, 4'h0, 32'h0, 1'b0);
    @(negedge clock);
    chk("bb2_stall", {31'h0, stallUpstream}, 32'h0);
    @(posedge clock); #1;
    chk("bb2_data", wbRdData, 32'h33333333);
    chk("bb2_addr", {27'h0, wbRdAddr}, 32'd12);

    // Reset while waiting on memory
    drive(32'h500, 5'd13, 2'b01, 1'b1, 1'b0, 3'b010, 32'h0, 4'h0, 32'h0, 1'b0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("wt_req", {31'h0, dmemRequest}, 32'h1);
    chk("wt_stall", {31'h0, stallUpstream}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rw_req", {31'h0, dmemRequest}, 32'h0);
    chk("rw_stall", {31'h0, stallUpstream}, 32'h0);
    chk("rw_we", {31'h0, wbRdWriteEnable}, 32'h0);
    chk("rw_data", wbRdData, 32'h0);
    drive(32'h55, 5'd7, 2'b00, 1'b1, 1'b0, 3'b010, 32'h0, 4'h0, 32'h0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("ar_req", {31'h0, dmemRequest}, 32'h0);
    chk("ar_stall", {31'h0, stallUpstream}, 32'h0);
    @(posedge clock); #1;
    chk("ar_data", wbRdData, 32'h55);
    chk("ar_we", {31'h0, wbRdWriteEnable}, 32'h1);
    chk("ar_addr", {27'h0, wbRdAddr}, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/jzjpcc_memory.md
# jzjpcc_memory

Memory stage of the jzjpcc five-stage pipeline: consumes the execute→memory pipeline register contents, performs data-memory loads and stores over a request/acknowledge handshake, extracts and sign/zero-extends load data, and registers the selected rd result into the memory→writeback pipeline register. It stalls the upstream pipeline while a memory access is outstanding and inserts a bubble into writeback during the stall.

## Interface
- DMEM_ADDR_B, default 30: width of the word address to data memory (byte address bits [31:2]).
- clock  in  1  pipeline clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- aluResult  in  32  ALU result from execute register; byte address for loads/stores.
- rdAddr  in  5  destination register.
- rdSource  in  2  rd select: 2'b00 ALU result, 2'b01 load data; 2'b10/2'b11 treated as ALU result.
- rdWriteEnable  in  1  instruction writes rd.
- memoryWriteEnable  in  1  instruction is a store.
- funct3  in  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW.
- memDataToWrite  in  32  store data, already lane-shifted by execute.
- memByteMask  in  4  store byte enables, already computed by execute.
- dmemRequest  out  1  access request to data memory.
- dmemAddress  out  DMEM_ADDR_B  aluResult[31:2].
- dmemWriteEnable  out  1  access is a store.
- dmemWriteData  out  32  = memDataToWrite.
- dmemByteMask  out  4  = memByteMask for stores, 4'b1111 for loads.
- dmemReadData  in  32  read word, valid in the cycle dmemAck is high.
- dmemAck  in  1  access complete this cycle.
- stallUpstream  out  1  execute and earlier stages hold their registers this cycle.
- wbRdAddr  out  5  registered rd address to writeback.
- wbRdData  out  32  registered rd value to writeback.
- wbRdWriteEnable  out  1  registered rd write enable to writeback.

## Operation
- memOp = memoryWriteEnable | (rdSource == 2'b01). Non-memory ops never touch data memory.
- FSM states: IDLE, WAIT.
- IDLE, no memOp: dmemRequest=0, stallUpstream=0; next edge registers wb* from inputs (wbRdData = aluResult).
- IDLE, memOp: dmemRequest=1 combinationally from inputs. If dmemAck same cycle: stallUpstream=0, register result, stay IDLE. Else: stallUpstream=1, go WAIT, wbRdWriteEnable<=0 (bubble).
- WAIT: dmemRequest=1, stallUpstream=1 until dmemAck; inputs are held stable by the stall. On ack: stallUpstream=0, register result, go IDLE. Without ack: wbRdWriteEnable<=0, stay WAIT.
- Request outputs (address, data, mask, write enable) are pure functions of the held inputs; stable throughout the request.
- Load extraction with off = aluResult[1:0]: byte = dmemReadData[8*off+7 : 8*off]; halfword = off[1] ? [31:16] : [15:0] (off[0] ignored, no misalignment trap); word = whole word, off ignored. LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
- Store: wbRdWriteEnable registered as rdWriteEnable (normally 0); wbRdData = aluResult.
- dmemAck while dmemRequest=0 is ignored.

## Timing
- Reset values: state IDLE, wbRdAddr=0, wbRdData=0, wbRdWriteEnable=0; dmemRequest and stallUpstream are 0 while reset is held (combinational from IDLE with wb cleared; dmemRequest forced 0 during reset).
- Latency: one cycle, input to wb*, when memory acks in the request cycle; 1+N cycles when ack arrives N cycles later; each non-ack cycle emits one bubble.
- stallUpstream is combinational and equals (memOp & ~dmemAck) in IDLE, ~dmemAck in WAIT.
- Back-to-back memory ops with same-cycle ack: one per cycle, no bubbles.
- Reset asserted in WAIT: immediate return to IDLE, request and stall drop asynchronously, outstanding access abandoned.

## Test plan
- ALU op: aluResult=0x12345678, rdAddr=5, rdSource=00, rdWriteEnable=1 -> next cycle wbRdData=0x12345678, wbRdAddr=5, wbRdWriteEnable=1, dmemRequest never high.
- LB/LBU, ack same cycle: aluResult=0x103, dmemReadData=0x80FF7F01 -> LB wbRdData=0xFFFFFF80, LBU 0x00000080, dmemAddress=0x40, no stall.
- LH/LHU at aluResult=0x102, dmemReadData=0x8001FFFF -> LH 0xFFFF8001, LHU 0x00008001; LW any offset -> 0x8001FFFF.
- Store with ack delayed 3 cycles: memoryWriteEnable=1, memByteMask=4'b1100, memDataToWrite=0xAABB0000 -> dmemRequest/dmemWriteEnable high 4 cycles, stallUpstream high 3 cycles, 3 bubbles, mask/data stable.
- Back-to-back LW,LW,ALU with immediate ack -> three consecutive writebacks, stallUpstream never high.
- Reset asserted during WAIT -> dmemRequest, stallUpstream, wbRdWriteEnable 0 immediately; after release, next ALU op completes normally in one cycle.
